// File: rtl/spi_pkg.sv
// Shared types for the SPI slave transmitter.
// Mode encoding, FSM states and the edge-select helper.
package spi_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  function automatic spi_mode_e spi_mode(
    input logic cpol,
    input logic cpha
  );
    return spi_mode_e'({cpol, cpha});
  endfunction

  function automatic logic sel_edge(
    input logic use_trail,
    input logic lead,
    input logic trail
  );
    return use_trail ? trail : lead;
  endfunction

endpackage

// File: rtl/spi_slave_tx_if.sv
// Fabric-side word stream into the SPI transmitter.
// The producer drives data/valid; the transmitter returns ready and level.
interface spi_slave_tx_if #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [LW-1:0]     fifo_level;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  fifo_level
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output fifo_level
  );

endinterface

// File: rtl/spi_tx_fifo.sv
// Synchronous TX FIFO; push and pop in one cycle are both honoured.
// Head word is always visible on rdata; no write-to-read bypass.
module spi_tx_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AW = $clog2(FIFO_DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;

  assign full  = (level == LW'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rp];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spi_slave_tx.sv
// SPI slave transmitter: FIFO-buffered words shifted out on MISO.
// SCK/SSEL are oversampled in the clk domain; all four SPI modes.
module spi_slave_tx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          CPOL       = 1'b0,
  parameter bit          CPHA       = 1'b0,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          FILL_BIT   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SCK,
  input  logic               SSEL,
  output logic               MISO,
  input  logic               enable,
  spi_slave_tx_if.slave      tx,
  output logic               word_sent,
  output logic               underflow,
  output logic               aborted
);

  localparam int unsigned CW = $clog2(DATA_W);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam spi_mode_e   MODE = spi_mode(CPOL, CPHA);
  localparam logic        PHA = (MODE == MODE1) || (MODE == MODE3);
  localparam logic [DATA_W-1:0] FILL_W = {DATA_W{FILL_BIT}};

  logic [2:0]        sck_q;
  logic [2:0]        ssel_q;
  logic              sck_lead;
  logic              sck_trail;
  logic              ssel_fall;
  logic              ssel_rise;

  spi_state_e        state;
  spi_state_e        state_n;
  logic              start;
  logic              run;
  logic              stop;
  logic              sample;
  logic              launch;
  logic              load;
  logic              shift;
  logic              wrap;
  logic              abort;

  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] sr_shifted;

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic [LW-1:0]     level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q  <= {3{CPOL}};
      ssel_q <= 3'b111;
    end else begin
      sck_q  <= {sck_q[1:0], SCK};
      ssel_q <= {ssel_q[1:0], SSEL};
    end
  end

  assign sck_lead  = (sck_q[1] != CPOL) && (sck_q[2] == CPOL);
  assign sck_trail = (sck_q[1] == CPOL) && (sck_q[2] != CPOL);
  assign ssel_fall = !ssel_q[1] && ssel_q[2];
  assign ssel_rise = ssel_q[1] && !ssel_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (ssel_fall && enable) state_n = ACTIVE;
      ACTIVE: if (ssel_rise || !enable) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Edges count only while staying active; a frame start is
  // itself a launch event for the CPHA=0 modes.
  assign start  = (state == IDLE) && (state_n == ACTIVE);
  assign run    = (state == ACTIVE) && (state_n == ACTIVE);
  assign stop   = (state == ACTIVE) && (state_n == IDLE);
  assign sample = run && sel_edge(PHA, sck_lead, sck_trail);
  assign launch = PHA ? (run && sck_lead)
                      : (start || (run && sck_trail));
  assign load   = launch && (cnt == '0);
  assign shift  = launch && (cnt != '0);
  assign wrap   = sample && (cnt == CW'(DATA_W - 1));
  assign abort  = stop && (cnt != '0);

  assign sr_shifted = MSB_FIRST ? {sr[DATA_W-2:0], FILL_BIT}
                                : {FILL_BIT, sr[DATA_W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      sr        <= FILL_W;
      word_sent <= 1'b0;
      underflow <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      word_sent <= wrap;
      underflow <= load && empty;
      aborted   <= abort;
      if (abort || wrap) begin
        cnt <= '0;
      end else if (sample) begin
        cnt <= cnt + 1'b1;
      end
      unique case (1'b1)
        load:    sr <= empty ? FILL_W : head;
        shift:   sr <= sr_shifted;
        default: sr <= sr;
      endcase
    end
  end

  assign MISO = MSB_FIRST ? sr[DATA_W-1] : sr[0];

  assign push = tx.tx_valid && !full;
  assign pop  = load && !empty;

  spi_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (tx.tx_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign tx.tx_ready   = !full;
  assign tx.fifo_level = level;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Scoreboard bench for spi_slave_tx: mode 0 / 8-bit MSB-first and
// modes 1-3 / 12-bit LSB-first instances driven by an SPI master model.
module tb_spi_slave_tx;

  localparam int HP = 8;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        sck  [4];
  logic        ssel [4];
  logic        miso [4];
  logic        ws   [4];
  logic        uf   [4];
  logic        ab   [4];
  logic [11:0] d    [4];
  logic        v    [4];
  logic        rdy  [4];
  logic [2:0]  lvl  [4];

  logic [11:0] exp_q [4][$];
  logic [11:0] rx    [4];
  int          uf_cnt [4];
  int          ab_cnt [4];
  int          max_lvl;
  int          n_chk;
  int          n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_slave_tx_if #(.DATA_W(8), .FIFO_DEPTH(4)) bus0 ();
  assign bus0.tx_data  = d[0][7:0];
  assign bus0.tx_valid = v[0];
  assign rdy[0]        = bus0.tx_ready;
  assign lvl[0]        = bus0.fifo_level;

  spi_slave_tx #(
    .DATA_W(8), .FIFO_DEPTH(4), .CPOL(1'b0), .CPHA(1'b0),
    .MSB_FIRST(1'b1), .FILL_BIT(1'b1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .SCK(sck[0]), .SSEL(ssel[0]),
    .MISO(miso[0]), .enable(enable), .tx(bus0),
    .word_sent(ws[0]), .underflow(uf[0]), .aborted(ab[0])
  );

  for (genvar g = 1; g < 4; g++) begin : g_m
    spi_slave_tx_if #(.DATA_W(12), .FIFO_DEPTH(4)) bus ();
    assign bus.tx_data  = d[g];
    assign bus.tx_valid = v[g];
    assign rdy[g]       = bus.tx_ready;
    assign lvl[g]       = bus.fifo_level;

    spi_slave_tx #(
      .DATA_W(12), .FIFO_DEPTH(4), .CPOL(g >= 2), .CPHA(g % 2 == 1),
      .MSB_FIRST(1'b0), .FILL_BIT(1'b1)
    ) dut (
      .clk(clk), .rst_n(rst_n), .SCK(sck[g]), .SSEL(ssel[g]),
      .MISO(miso[g]), .enable(enable), .tx(bus),
      .word_sent(ws[g]), .underflow(uf[g]), .aborted(ab[g])
    );
  end

  task automatic check(input string name, input int act, input int want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every word_sent pops one expected word and compares it
  // with what the master model assembled from MISO.
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (uf[m]) uf_cnt[m]++;
      if (ab[m]) ab_cnt[m]++;
      if (int'(lvl[m]) > max_lvl) max_lvl = int'(lvl[m]);
      if (ws[m]) begin
        if (exp_q[m].size() == 0) begin
          check($sformatf("extra_word%0d", m), int'(rx[m]), -1);
        end else begin
          logic [11:0] e;
          logic [11:0] mask;
          e = exp_q[m].pop_front();
          mask = (m == 0) ? 12'h0FF : 12'hFFF;
          check($sformatf("word%0d", m), int'(rx[m] & mask), int'(e));
        end
      end
    end
  end

  task automatic capture(input int m);
    if (m == 0) rx[m] = {rx[m][10:0], miso[m]};
    else        rx[m] = {miso[m], rx[m][11:1]};
  endtask

  task automatic push(input int m, input logic [11:0] w);
    int t;
    t = 0;
    exp_q[m].push_back(w);
    d[m] = w;
    v[m] = 1'b1;
    while (!rdy[m] && t < 400) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("push_ready%0d", m), int'(rdy[m]), 1);
    @(negedge clk);
    v[m] = 1'b0;
  endtask

  // CPHA=0 frames end after the last sample edge: SSEL rises before
  // SCK returns to idle, so no launch follows the final bit.
  task automatic frame(input int m, input int nbits, input bit close);
    bit pol;
    bit pha;
    pol = (m >= 2);
    pha = (m % 2 == 1);
    ssel[m] = 1'b0;
    wait_clk(HP);
    for (int b = 0; b < nbits; b++) begin
      if (!pha) begin
        capture(m);
        sck[m] = ~pol;
        wait_clk(HP);
        if (b != nbits - 1) begin
          sck[m] = pol;
          wait_clk(HP);
        end
      end else begin
        sck[m] = ~pol;
        wait_clk(HP);
        capture(m);
        sck[m] = pol;
        wait_clk(HP);
      end
    end
    if (close) begin
      ssel[m] = 1'b1;
      wait_clk(HP);
      sck[m] = pol;
      wait_clk(HP);
    end
  endtask

  initial begin
    int u0;
    int a0;
    n_chk = 0;
    n_pass = 0;
    max_lvl = 0;
    rst_n = 1'b0;
    enable = 1'b1;
    for (int m = 0; m < 4; m++) begin
      sck[m] = (m >= 2);
      ssel[m] = 1'b1;
      d[m] = '0;
      v[m] = 1'b0;
      rx[m] = '0;
      uf_cnt[m] = 0;
      ab_cnt[m] = 0;
    end
    wait_clk(3);
    check("rst_miso", int'(miso[0]), 1);
    check("rst_ready", int'(rdy[0]), 1);
    check("rst_level", int'(lvl[0]), 0);
    check("rst_miso3", int'(miso[3]), 1);
    rst_n = 1'b1;
    wait_clk(3);

    // Mode 0: two words back to back in one frame
    push(0, 12'hA5);
    push(0, 12'h3C);
    check("t1_level2", int'(lvl[0]), 2);
    frame(0, 16, 1'b1);
    wait_clk(10);
    check("t1_level0", int'(lvl[0]), 0);
    check("t1_pending", exp_q[0].size(), 0);
    check("t1_underflow", uf_cnt[0], 0);

    // Modes 1..3, 12-bit LSB first
    for (int m = 1; m < 4; m++) begin
      push(m, 12'h8F1);
      frame(m, 12, 1'b1);
      wait_clk(10);
      check($sformatf("t2_pending%0d", m), exp_q[m].size(), 0);
      check($sformatf("t2_underflow%0d", m), uf_cnt[m], 0);
      check($sformatf("t2_abort%0d", m), ab_cnt[m], 0);
    end

    // Empty FIFO sends fill bits
    u0 = uf_cnt[0];
    exp_q[0].push_back(12'hFF);
    frame(0, 8, 1'b1);
    wait_clk(10);
    check("t3_underflow", uf_cnt[0] - u0, 1);
    check("t3_pending", exp_q[0].size(), 0);

    // Abort after 3 bits; the partial word is dropped
    a0 = ab_cnt[0];
    push(0, 12'hFF);
    frame(0, 3, 1'b1);
    wait_clk(10);
    check("t4_abort", ab_cnt[0] - a0, 1);
    check("t4_unsent", exp_q[0].size(), 1);
    check("t4_level", int'(lvl[0]), 0);
    exp_q[0].delete();
    push(0, 12'h11);
    frame(0, 8, 1'b1);
    wait_clk(10);
    check("t4_pending", exp_q[0].size(), 0);

    // FIFO full: 5th push waits for the first pop
    max_lvl = 0;
    push(0, 12'h01);
    push(0, 12'h02);
    push(0, 12'h04);
    push(0, 12'h08);
    check("t5_ready_full", int'(rdy[0]), 0);
    check("t5_level4", int'(lvl[0]), 4);
    fork
      push(0, 12'h10);
      frame(0, 40, 1'b1);
    join
    wait_clk(10);
    check("t5_pending", exp_q[0].size(), 0);
    check("t5_max_level", max_lvl, 4);
    check("t5_level0", int'(lvl[0]), 0);
    check("t5_ready", int'(rdy[0]), 1);

    // enable=0: frame ignored, push still accepted
    enable = 1'b0;
    push(0, 12'h6E);
    frame(0, 8, 1'b1);
    wait_clk(10);
    check("t6_level", int'(lvl[0]), 1);
    check("t6_unsent", exp_q[0].size(), 1);
    enable = 1'b1;
    wait_clk(2);
    frame(0, 8, 1'b1);
    wait_clk(10);
    check("t6_pending", exp_q[0].size(), 0);

    // Reset mid-word
    push(0, 12'hA5);
    frame(0, 3, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("t7_miso", int'(miso[0]), 1);
    check("t7_level", int'(lvl[0]), 0);
    check("t7_ready", int'(rdy[0]), 1);
    check("t7_pulses", int'({ws[0], uf[0], ab[0]}), 0);
    exp_q[0].delete();
    ssel[0] = 1'b1;
    sck[0] = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);
    push(0, 12'h5A);
    frame(0, 8, 1'b1);
    wait_clk(10);
    check("t7_pending", exp_q[0].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
